vliw_scoreboard: RTL

Register-hazard scoreboard for the 4-slot VLIW core. It sits between decode/issue and the 64-entry, 4-write / 8-read register file. It tracks which architectural registers have a write in flight and holds the issue bundle while any slot's source or destination is still pending. Busy bits are set when a bundle is accepted and cleared by the same four write ports that drive the register file. The register file forwards same-cycle write data to its read ports, so a register being written this cycle is treated as available.

---
 rtl/vliw_scoreboard.sv | 101 ++++++++++
 1 files changed

// File: rtl/vliw_scoreboard.sv
// Register-hazard scoreboard for the 4-slot VLIW issue stage.
// Tracks in-flight writes per register and holds bundles on RAW/WAW hazards.
module vliw_scoreboard #(
    parameter int NSLOT = 4,
    parameter int AW    = 6,
    localparam int NREG = 1 << AW,
    localparam int CW   = $clog2(NREG + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [NSLOT-1:0]      iss_slot_v,
    input  logic [NSLOT*AW-1:0]   iss_rs1,
    input  logic [NSLOT-1:0]      iss_rs1_en,
    input  logic [NSLOT*AW-1:0]   iss_rs2,
    input  logic [NSLOT-1:0]      iss_rs2_en,
    input  logic [NSLOT*AW-1:0]   iss_rd,
    input  logic [NSLOT-1:0]      iss_rd_en,
    output logic                  iss_ready,
    input  logic [NSLOT-1:0]      wb_we,
    input  logic [NSLOT*AW-1:0]   wb_wa,
    output logic [NREG-1:0]       busy_vec,
    output logic [CW-1:0]         busy_cnt,
    output logic                  err
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [NREG-1:0] wb_hit;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] set_vec;
    logic            ready;
    logic            accept;
    logic            wb_err;
    logic            dup_err;

    always_comb begin
        wb_hit = '0;
        for (int j = 0; j < NSLOT; j++) begin
            if (wb_we[j]) wb_hit[wb_wa[j*AW +: AW]] = 1'b1;
        end
        // Same-cycle write-back is forwarded by the register file, so it never stalls.
        pending = busy_q & ~wb_hit;

        ready = 1'b1;
        for (int k = 0; k < NSLOT; k++) begin
            if (iss_slot_v[k] && iss_rs1_en[k] && pending[iss_rs1[k*AW +: AW]]) ready = 1'b0;
            if (iss_slot_v[k] && iss_rs2_en[k] && pending[iss_rs2[k*AW +: AW]]) ready = 1'b0;
            if (iss_slot_v[k] && iss_rd_en[k]  && pending[iss_rd[k*AW +: AW]])  ready = 1'b0;
        end
        accept = iss_valid & ready;

        set_vec = '0;
        dup_err = 1'b0;
        for (int k = 0; k < NSLOT; k++) begin
            if (accept && iss_slot_v[k] && iss_rd_en[k] && (iss_rd[k*AW +: AW] != '0)) begin
                set_vec[iss_rd[k*AW +: AW]] = 1'b1;
                for (int m = k + 1; m < NSLOT; m++) begin
                    if (iss_slot_v[m] && iss_rd_en[m] && (iss_rd[m*AW +: AW] == iss_rd[k*AW +: AW]))
                        dup_err = 1'b1;
                end
            end
        end

        wb_err = 1'b0;
        for (int j = 0; j < NSLOT; j++) begin
            if (wb_we[j] && (wb_wa[j*AW +: AW] != '0) && !busy_q[wb_wa[j*AW +: AW]]
                && !set_vec[wb_wa[j*AW +: AW]])
                wb_err = 1'b1;
        end

        // Set wins over clear when a register is released and re-claimed together.
        busy_d = (busy_q & ~wb_hit) | set_vec;
        err_d  = err_q | wb_err | dup_err;

        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + CW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign iss_ready = ready;
    assign busy_vec  = busy_q;
    assign busy_cnt  = cnt_q;
    assign err       = err_q;

endmodule
